// File: rtl/ccc_tgt_engine_v2.sv
// HDR-DDR Common Command Code sequencer for the I3C target: walks each CCC frame word by word
// and moves data bytes to/from the regfile. Define CCC_GETPID_EN to support direct GETPID (0x8D).
module ccc_tgt_engine_v2 #(
    parameter int unsigned        REGF_AW   = 8,
    parameter int unsigned        MAX_BYTES = 6,
    parameter logic [REGF_AW-1:0] MWL_BASE  = 'h00,
    parameter logic [REGF_AW-1:0] MRL_BASE  = 'h02,
    parameter logic [REGF_AW-1:0] STAT_BASE = 'h04,
    parameter logic [REGF_AW-1:0] PID_BASE  = 'h10,
    parameter logic [REGF_AW-1:0] DEF_ADDR  = 'hFF
) (
    input  logic               i_sys_clk,
    input  logic               i_sys_rst,
    input  logic               i_engine_en,
    input  logic               i_rx_mode_done,
    input  logic               i_tx_mode_done,
    input  logic               i_rx_error,
    input  logic               i_rx_preamble,
    input  logic               i_restart_done,
    input  logic               i_exit_done,
    input  logic [7:0]         i_ccc_value,
    output logic               o_rx_en,
    output logic [3:0]         o_rx_mode,
    output logic               o_tx_en,
    output logic [2:0]         o_tx_mode,
    output logic [REGF_AW-1:0] o_regf_addr,
    output logic               o_regf_wr_en,
    output logic               o_regf_rd_en,
    output logic               o_engine_done,
    output logic               o_ccc_err
);
    localparam int unsigned CW = $clog2(MAX_BYTES + 1);

    typedef enum logic [4:0] {
        StIdle, StPreCmd, StAck, StCccVal, StDefByte, StParity, StZeros, StAddr, StData,
        StGetRd, StGetTx, StTxPar, StTxCrc, StSpecPre, StTokenCrc, StCrcVal, StWaitRs
    } state_e;

    state_e             state_q, state_d;
    logic               dir_q, dir_d, data_q, data_d, get_q, get_d;
    logic [CW-1:0]      cnt_q, cnt_d, nb_q, nb_d, cnt_inc;
    logic [REGF_AW-1:0] base_q, base_d, addr_q, addr_d;
    logic               rx_en_q, rx_en_d, tx_en_q, tx_en_d;
    logic [3:0]         rx_mode_q, rx_mode_d;
    logic [2:0]         tx_mode_q, tx_mode_d;
    logic               wr_q, wr_d, rd_q, rd_d, done_q, done_d, err_q, err_d;

    logic               dec_ok, dec_get;
    int unsigned        dec_raw;
    logic [REGF_AW-1:0] dec_base;
    logic [CW-1:0]      dec_nb;

    always_comb begin
        dec_ok   = 1'b1;
        dec_get  = 1'b0;
        dec_raw  = 0;
        dec_base = '0;
        case (i_ccc_value)
            8'h00, 8'h01, 8'h80, 8'h81, 8'h2A, 8'h9A: ;
            8'h09, 8'h89: begin dec_raw = 2; dec_base = MWL_BASE; end
            8'h0A, 8'h8A: begin dec_raw = 2; dec_base = MRL_BASE; end
            8'h8B: begin dec_raw = 2; dec_base = MWL_BASE; dec_get = 1'b1; end
            8'h8C: begin dec_raw = 2; dec_base = MRL_BASE; dec_get = 1'b1; end
            8'h90: begin dec_raw = 2; dec_base = STAT_BASE; dec_get = 1'b1; end
            8'h8E: begin dec_raw = 1; dec_base = STAT_BASE + REGF_AW'(2); dec_get = 1'b1; end
            8'h8F: begin dec_raw = 1; dec_base = STAT_BASE + REGF_AW'(3); dec_get = 1'b1; end
`ifdef CCC_GETPID_EN
            8'h8D: begin dec_raw = 6; dec_base = PID_BASE; dec_get = 1'b1; end
`endif
            default: dec_ok = 1'b0;
        endcase
        dec_nb = (dec_raw > MAX_BYTES) ? CW'(MAX_BYTES) : CW'(dec_raw);
    end

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        data_d  = data_q;
        get_d   = get_q;
        cnt_d   = cnt_q;
        nb_d    = nb_q;
        base_d  = base_q;
        addr_d  = '0;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (state_q != StIdle && !i_engine_en) begin
            state_d = StIdle;
            dir_d   = 1'b0;
            data_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: if (i_engine_en) state_d = StPreCmd;
                StPreCmd: if (i_rx_mode_done) begin
                    if (i_rx_preamble) state_d = StAck;
                    else if (data_q) state_d = StData;
                    else begin state_d = StIdle; done_d = 1'b1; end
                end
                StAck: if (i_tx_mode_done) begin
                    if (!data_q) state_d = StCccVal;
                    else if (dir_q) state_d = StZeros;
                    else begin state_d = StIdle; done_d = 1'b1; err_d = 1'b1; end
                end
                StCccVal: if (i_rx_mode_done) begin
                    if (!dec_ok) begin
                        state_d = StIdle; done_d = 1'b1; err_d = 1'b1;
                    end else begin
                        dir_d   = i_ccc_value[7];
                        nb_d    = dec_nb;
                        base_d  = dec_base;
                        get_d   = dec_get;
                        state_d = StDefByte;
                        wr_d    = 1'b1;
                        addr_d  = DEF_ADDR;
                    end
                end
                StDefByte: if (i_rx_mode_done) state_d = StParity;
                StParity: if (i_rx_mode_done) begin
                    if (i_rx_error) begin state_d = StIdle; done_d = 1'b1; err_d = 1'b1; end
                    else if (nb_q != '0 && !data_q) begin data_d = 1'b1; state_d = StPreCmd; end
                    else state_d = StSpecPre;
                end
                StZeros: if (i_rx_mode_done) state_d = StAddr;
                StAddr: if (i_rx_mode_done) begin
                    // Address mismatch means the frame is for another target: quiet release.
                    if (i_rx_error) begin state_d = StIdle; done_d = 1'b1; end
                    else if (get_q) begin
                        state_d = StGetRd; rd_d = 1'b1; addr_d = base_q + REGF_AW'(cnt_q);
                    end else state_d = StData;
                end
                StData: begin
                    if (cnt_q >= nb_q) state_d = StParity;
                    else if (i_rx_mode_done) begin
                        wr_d   = 1'b1;
                        addr_d = base_q + REGF_AW'(cnt_q);
                        cnt_d  = cnt_inc;
                        if (cnt_inc >= nb_q) state_d = StParity;
                    end
                end
                StGetRd: state_d = StGetTx;
                StGetTx: if (i_tx_mode_done) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= nb_q) state_d = StTxPar;
                    else begin
                        state_d = StGetRd; rd_d = 1'b1; addr_d = base_q + REGF_AW'(cnt_inc);
                    end
                end
                StTxPar: if (i_tx_mode_done) state_d = StTxCrc;
                StTxCrc: if (i_tx_mode_done) begin
                    state_d = StWaitRs; data_d = 1'b0; cnt_d = '0;
                end
                StSpecPre, StTokenCrc, StCrcVal: if (i_rx_mode_done) begin
                    if (i_rx_error) begin state_d = StIdle; done_d = 1'b1; err_d = 1'b1; end
                    else if (state_q == StSpecPre) state_d = StTokenCrc;
                    else if (state_q == StTokenCrc) state_d = StCrcVal;
                    else begin state_d = StWaitRs; data_d = 1'b0; cnt_d = '0; end
                end
                StWaitRs: begin
                    if (i_exit_done) begin state_d = StIdle; done_d = 1'b1; end
                    else if (i_restart_done) state_d = StPreCmd;
                end
                default: state_d = StIdle;
            endcase
        end
        if (done_d) begin
            dir_d  = 1'b0;
            data_d = 1'b0;
            cnt_d  = '0;
        end

        // Level outputs follow the destination state so they are valid on its first cycle.
        rx_en_d   = 1'b0;
        rx_mode_d = 4'd0;
        tx_en_d   = 1'b0;
        tx_mode_d = 3'd0;
        unique case (state_d)
            StPreCmd:   begin rx_en_d = 1'b1; rx_mode_d = 4'd0; end
            StCccVal:   begin rx_en_d = 1'b1; rx_mode_d = 4'd1; end
            StDefByte:  begin rx_en_d = 1'b1; rx_mode_d = 4'd2; end
            StData:     begin rx_en_d = 1'b1; rx_mode_d = 4'd2; end
            StParity:   begin rx_en_d = 1'b1; rx_mode_d = 4'd3; end
            StSpecPre:  begin rx_en_d = 1'b1; rx_mode_d = 4'd4; end
            StZeros:    begin rx_en_d = 1'b1; rx_mode_d = 4'd5; end
            StAddr:     begin rx_en_d = 1'b1; rx_mode_d = 4'd6; end
            StTokenCrc: begin rx_en_d = 1'b1; rx_mode_d = 4'd7; end
            StCrcVal:   begin rx_en_d = 1'b1; rx_mode_d = 4'd8; end
            StAck:      begin tx_en_d = 1'b1; tx_mode_d = 3'd1; end
            StGetTx:    begin tx_en_d = 1'b1; tx_mode_d = 3'd2; end
            StTxPar:    begin tx_en_d = 1'b1; tx_mode_d = 3'd3; end
            StTxCrc:    begin tx_en_d = 1'b1; tx_mode_d = 3'd4; end
            default: ;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q   <= StIdle;
            dir_q     <= 1'b0;
            data_q    <= 1'b0;
            get_q     <= 1'b0;
            cnt_q     <= '0;
            nb_q      <= '0;
            base_q    <= '0;
            addr_q    <= '0;
            rx_en_q   <= 1'b0;
            rx_mode_q <= 4'd0;
            tx_en_q   <= 1'b0;
            tx_mode_q <= 3'd0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            data_q    <= data_d;
            get_q     <= get_d;
            cnt_q     <= cnt_d;
            nb_q      <= nb_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            rx_en_q   <= rx_en_d;
            rx_mode_q <= rx_mode_d;
            tx_en_q   <= tx_en_d;
            tx_mode_q <= tx_mode_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign o_rx_en       = rx_en_q;
    assign o_rx_mode     = rx_mode_q;
    assign o_tx_en       = tx_en_q;
    assign o_tx_mode     = tx_mode_q;
    assign o_regf_addr   = addr_q;
    assign o_regf_wr_en  = wr_q;
    assign o_regf_rd_en  = rd_q;
    assign o_engine_done = done_q;
    assign o_ccc_err     = err_q;

endmodule

// File: tb/tb_ccc_tgt_engine_v2.sv
// Randomised frame-level bench for ccc_tgt_engine_v2: a bus responder answers each RX/TX phase
// and the regfile strobes, TX phases and completion are compared with a scenario-level model.
module tb_ccc_tgt_engine_v2;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, rx_done = 1'b0, tx_done = 1'b0, rx_err = 1'b0, rx_pre = 1'b0;
    logic       restart = 1'b0, exit_p = 1'b0;
    logic [7:0] ccc = 8'h00;
    logic       rx_en, tx_en, wr, rd, done, err;
    logic [3:0] rx_mode;
    logic [2:0] tx_mode;
    logic [7:0] addr;

    always #5 clk = ~clk;

    ccc_tgt_engine_v2 dut (
        .i_sys_clk      (clk),
        .i_sys_rst      (rst_n),
        .i_engine_en    (en),
        .i_rx_mode_done (rx_done),
        .i_tx_mode_done (tx_done),
        .i_rx_error     (rx_err),
        .i_rx_preamble  (rx_pre),
        .i_restart_done (restart),
        .i_exit_done    (exit_p),
        .i_ccc_value    (ccc),
        .o_rx_en        (rx_en),
        .o_rx_mode      (rx_mode),
        .o_tx_en        (tx_en),
        .o_tx_mode      (tx_mode),
        .o_regf_addr    (addr),
        .o_regf_wr_en   (wr),
        .o_regf_rd_en   (rd),
        .o_engine_done  (done),
        .o_ccc_err      (err)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    int unsigned exp_wr[$], exp_rd[$], exp_tx[$];
    int unsigned got_wr[$], got_rd[$], got_tx[$];
    bit          exp_err;
    logic [7:0]  codes[16] = '{8'h00, 8'h01, 8'h80, 8'h81, 8'h2A, 8'h9A, 8'h09, 8'h0A,
                               8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8E, 8'h8F, 8'h90, 8'h8D};
    int          err_modes[8] = '{0, 0, 0, 3, 4, 6, 7, 8};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] outs();
        return {11'd0, rx_en, rx_mode, tx_en, tx_mode, addr, wr, rd, done, err};
    endfunction

    // Expected regfile traffic, TX phases and outcome of one frame, from the CCC rules.
    task automatic build_expect(input logic [7:0] code, input int err_mode);
        bit          sup = 1'b1, get = 1'b0;
        int unsigned n = 0, base = 0;
        exp_wr.delete(); exp_rd.delete(); exp_tx.delete();
        exp_err = 1'b0;
        case (code)
            8'h00, 8'h01, 8'h80, 8'h81, 8'h2A, 8'h9A: ;
            8'h09, 8'h89: begin n = 2; base = 0; end
            8'h0A, 8'h8A: begin n = 2; base = 2; end
            8'h8B: begin n = 2; base = 0; get = 1; end
            8'h8C: begin n = 2; base = 2; get = 1; end
            8'h90: begin n = 2; base = 4; get = 1; end
            8'h8E: begin n = 1; base = 6; get = 1; end
            8'h8F: begin n = 1; base = 7; get = 1; end
`ifdef CCC_GETPID_EN
            8'h8D: begin n = 6; base = 16; get = 1; end
`endif
            default: sup = 1'b0;
        endcase
        exp_tx.push_back(1);
        if (!sup) begin exp_err = 1'b1; return; end
        exp_wr.push_back(8'hFF);
        if (err_mode == 3) begin exp_err = 1'b1; return; end
        if (n > 0) begin
            if (code[7]) begin
                exp_tx.push_back(1);
                if (err_mode == 6) return;
            end
            for (int i = 0; i < int'(n); i++) begin
                if (get) begin exp_rd.push_back(base + i); exp_tx.push_back(2); end
                else exp_wr.push_back(base + i);
            end
            if (get) begin exp_tx.push_back(3); exp_tx.push_back(4); return; end
        end
        if (err_mode == 4 || err_mode == 7 || err_mode == 8) exp_err = 1'b1;
    endtask

    task automatic cmp_list(input string tag, input int unsigned g[$], input int unsigned e[$]);
        check_eq({tag, "_count"}, g.size(), e.size());
        for (int i = 0; i < e.size() && i < g.size(); i++)
            check_eq($sformatf("%s[%0d]", tag, i), g[i], e[i]);
    endtask

    // wait_act in WAIT_RS: 0 exit, 1 exit+restart together, 2 restart then plain preamble.
    task automatic run_frame(input logic [7:0] code, input int err_mode, input int wait_act,
                             input int abort_wr);
        bit done_seen = 0, aborted = 0, restarted = 0, parity_seen = 0, got_err = 0, nd = 0;
        int cyc = 0, last_rel = 0, done_cyc = 0, idle_run = 0, pre_idx = 0, wait_cnt;
        build_expect(code, err_mode);
        got_wr.delete(); got_rd.delete(); got_tx.delete();
        wait_cnt = $urandom_range(0, 2);
        ccc = code;
        @(negedge clk);
        en = 1'b1;
        while (!done_seen && !aborted && cyc < 600) begin
            @(negedge clk);
            cyc++;
            {rx_done, tx_done, rx_err, restart, exit_p} = '0;
            if (wr) got_wr.push_back(addr);
            if (rd) got_rd.push_back(addr);
            if (done) begin
                done_seen = 1; got_err = err; done_cyc = cyc; en = 1'b0;
            end else if (abort_wr > 0 && got_wr.size() == abort_wr) begin
                aborted = 1; en = 1'b0;
            end else begin
                if (rx_en || tx_en) idle_run = 0;
                else idle_run++;
                if (rx_en) begin
                    if (wait_cnt > 0) wait_cnt--;
                    else begin
                        rx_done = 1'b1; last_rel = cyc; wait_cnt = $urandom_range(0, 2);
                        if (rx_mode == 4'd0) begin
                            rx_pre = restarted ? 1'b0 : (pre_idx == 0 ? 1'b1 : code[7]);
                            pre_idx++;
                        end
                        if (err_mode != 0 && rx_mode == 4'(err_mode) &&
                            !(err_mode == 3 && parity_seen)) rx_err = 1'b1;
                        if (rx_mode == 4'd3) parity_seen = 1;
                        if ($urandom_range(0, 3) == 0) tx_done = 1'b1;
                    end
                end else if (tx_en) begin
                    if (wait_cnt > 0) wait_cnt--;
                    else begin
                        tx_done = 1'b1; last_rel = cyc; wait_cnt = $urandom_range(0, 2);
                        got_tx.push_back(tx_mode);
                        if ($urandom_range(0, 3) == 0) rx_done = 1'b1;
                    end
                end else if (idle_run >= 2) begin
                    last_rel = cyc; idle_run = 0;
                    if (wait_act == 2 && !restarted) begin restart = 1'b1; restarted = 1; end
                    else begin exit_p = 1'b1; restart = (wait_act == 1); end
                end
            end
        end
        {rx_done, tx_done, rx_err, restart, exit_p} = '0;
        if (aborted) begin
            @(negedge clk);
            check_eq("abort_outs", outs(), 0);
            repeat (3) begin @(negedge clk); nd = nd | done; end
            check_eq("abort_no_done", nd, 0);
        end else if (!done_seen) begin
            check_eq("timeout", 0, 1);
            en = 1'b0;
        end else begin
            cmp_list($sformatf("wr_%02h", code), got_wr, exp_wr);
            cmp_list($sformatf("rd_%02h", code), got_rd, exp_rd);
            cmp_list($sformatf("tx_%02h", code), got_tx, exp_tx);
            check_eq($sformatf("err_%02h", code), got_err, exp_err);
            check_eq("done_latency", done_cyc - last_rel, 1);
            @(negedge clk);
            check_eq("post_done_outs", outs(), 0);
        end
    endtask

    initial begin
        int c, e;
        repeat (2) @(negedge clk);
        check_eq("rst_outs", outs(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_outs", outs(), 0);
        run_frame(8'h00, 0, 0, 0);
        run_frame(8'h09, 0, 0, 0);
        run_frame(8'h8C, 0, 1, 0);
        run_frame(8'h55, 0, 0, 0);
        run_frame(8'h0A, 3, 0, 0);
        run_frame(8'h09, 0, 0, 2);
        run_frame(8'h8D, 0, 0, 0);
        run_frame(8'h8E, 0, 2, 0);
        run_frame(8'h90, 6, 0, 0);
        run_frame(8'h89, 8, 1, 0);
        run_frame(8'h2A, 7, 0, 0);
        run_frame(8'h8F, 4, 2, 0);
        for (int i = 0; i < 40; i++) begin
            c = $urandom_range(0, 15);
            e = $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) run_frame(8'($urandom), err_modes[e], 0, 0);
            else run_frame(codes[c], err_modes[e], $urandom_range(0, 2), 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
